dense_requant_relu: RTL and testbench
=====================================

// Module: dense_requant_relu
// PURPOSE
//  Post-processing stage directly downstream of the dense-layer MAC top. Takes one signed
//  accumulator per output neuron, adds that neuron's bias, applies ReLU, then rounds,
//  shifts and saturates the result to int8.
//  Writes each activation to the output buffer and tracks the argmax (class index) for the
//  classifier stage.
// PARAMETERS
//  NUM_NEURONS  32  output neurons per inference (accumulators accepted per start)
//  ACC_W        32  accumulator width, signed two's complement
//  BIAS_W       16  bias word width, signed
//  OUT_W         8  activation width; output range is 0..(2^(OUT_W-1))-1
//  SHIFT         8  requant right-shift amount, 0..ACC_W-1
//  IDX_W         5  neuron index width, clog2(NUM_NEURONS)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       reset, asynchronous, active-high
//  start        in   1       pulse: clear neuron counter, argmax and pipeline; arm block
//  acc_valid    in   1       acc_data valid this cycle; no backpressure
//  acc_data     in   ACC_W   neuron accumulator, signed
//  bias_addr    out  IDX_W   bias ROM address
//  bias_data    in   BIAS_W  bias ROM data, valid 1 cycle after bias_addr (sync read)
//  out_valid    out  1       out_addr/out_data valid; one-cycle write strobe
//  out_addr     out  IDX_W   neuron index of out_data
//  out_data     out  OUT_W   activation, unsigned value 0..127 in signed int8 container
//  argmax_idx   out  IDX_W   index of largest activation so far
//  argmax_val   out  OUT_W   value of largest activation so far
//  busy         out  1       armed and not done
//  done         out  1       one-cycle pulse after the last neuron's out_valid
// BEHAVIOUR
//  Reset: all outputs 0, neuron counter 0, pipeline valids 0, block idle (busy=0).
//  start: synchronous, highest priority. Clears counter, argmax_idx/val=0 and all pipeline
//   valids. Sets busy=1. An acc_valid in the same cycle is dropped.
//  Accept: when busy & acc_valid & count<NUM_NEURONS:
//   - register acc_data (S0)
//   - bias_addr<=count
//   - count++
//   acc_valid while idle or at count==NUM_NEURONS is ignored.
//  Pipeline, one sample per cycle sustained:
//   S0: acc, idx registered; bias_addr driven
//   S1: sum = sext(acc,ACC_W+1) + sext(bias_data,ACC_W+1); no wrap possible
//   S2: r = (sum<0) ? 0 : sum
//       r = (SHIFT>0) ? (r + 2^(SHIFT-1)) >>> SHIFT : r   (round half up)
//       out_data = min(r,127)
//       out_valid=1, out_addr=idx
//  Latency: acc_valid edge -> out_valid high exactly 3 cycles later. Gaps in acc_valid
//   propagate as gaps in out_valid.
//  Argmax: updated on out_valid when out_data > argmax_val (strict); ties keep lowest
//   index. Because values are >=0 and init=0, an all-zero layer yields idx 0.
//  done: pulses the cycle after out_valid with out_addr==NUM_NEURONS-1. busy drops the
//   same cycle. argmax_* hold until next start or rst.
//  start mid-operation: in-flight samples discarded, no out_valid for them, no done.
//  rst mid-operation: asynchronous return to reset state, no further strobes.
// STRUCTURE
//  Shared package dense_pkg:
//   - constants NUM_NEURONS, ACC_W, OUT_W, IDX_W, SHIFT_DENSE (shared with MAC top and
//     classifier)
//   - OUT_MAX = 2^(OUT_W-1)-1
//  Sub-module requant_sat (combinational, S2 datapath): ACC_W+1 signed in ->
//   ReLU/round/shift/saturate -> OUT_W out. Reusable by conv stages.
//  Top: counter, 3-stage valid pipeline, bias ROM addressing, argmax register, done logic.
// TESTING
//  1 Reset: assert rst mid-stream -> all outputs 0 next edge; no out_valid until start.
//  2 Basic: bias=0, SHIFT=8. acc=0x0000_3280 -> 0x33 (round up from 0x32.80).
//    acc=0x0000_327F -> 0x32. Both land 3 cycles after acc_valid.
//  3 ReLU/saturate:
//    acc=-5000, bias=+100 -> 0
//    acc=0x7FFF_FFFF, bias=0x7FFF -> 127 (no wrap)
//    acc=0x8000_0000, bias=0x8000 -> 0
//  4 Full layer back-to-back: 32 consecutive acc_valid. Acc(n)=n*256, except n=17 gets
//    120*256 and n=20 also 120*256. Expect out_addr 0..31 contiguous, done once 1 cycle
//    after addr 31, argmax_idx=17, argmax_val=120.
//  5 Overflow input: 33rd acc_valid after 32 accepted -> ignored; no extra out_valid;
//    bias_addr unchanged.
//  6 start mid-layer: start after 10 samples with 2 in flight -> no out_valid for the
//    in-flight pair. New layer restarts at out_addr 0; argmax cleared to 0/0.

Source files
------------

// File: rtl/dense_pkg.sv
// rtl/dense_pkg.sv - shared dense-layer constants
package dense_pkg;
    localparam int NUM_NEURONS = 32;
    localparam int ACC_W       = 32;
    localparam int BIAS_W      = 16;
    localparam int OUT_W       = 8;
    localparam int IDX_W       = 5;
    localparam int SHIFT_DENSE = 8;
    localparam int OUT_MAX     = (1 << (OUT_W - 1)) - 1;
    localparam int SUM_W       = ACC_W + 1;
endpackage

// File: rtl/dense_requant_relu_if.sv
// rtl/dense_requant_relu_if.sv - requant/relu stage signal bundle
interface dense_requant_relu_if;
    import dense_pkg::*;

    logic                     start;
    logic                     acc_valid;
    logic signed [ACC_W-1:0]  acc_data;
    logic [IDX_W-1:0]         bias_addr;
    logic signed [BIAS_W-1:0] bias_data;
    logic                     out_valid;
    logic [IDX_W-1:0]         out_addr;
    logic [OUT_W-1:0]         out_data;
    logic [IDX_W-1:0]         argmax_idx;
    logic [OUT_W-1:0]         argmax_val;
    logic                     busy;
    logic                     done;

    modport slave (
        input  start, acc_valid, acc_data, bias_data,
        output bias_addr, out_valid, out_addr, out_data,
        output argmax_idx, argmax_val, busy, done
    );

    modport master (
        output start, acc_valid, acc_data, bias_data,
        input  bias_addr, out_valid, out_addr, out_data,
        input  argmax_idx, argmax_val, busy, done
    );
endinterface

// File: rtl/dense_requant_relu_requant_sat.sv
// rtl/dense_requant_relu_requant_sat.sv - relu, round-half-up shift, saturate
module requant_sat
    import dense_pkg::*;
#(
    parameter int IN_W  = SUM_W,
    parameter int O_W   = OUT_W,
    parameter int SHIFT = SHIFT_DENSE
) (
    input  logic signed [IN_W-1:0] din,
    output logic [O_W-1:0]         dout
);
    localparam int            HS   = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [IN_W:0] HALF = (SHIFT > 0) ? ((IN_W + 1)'(1) << HS) : '0;
    localparam logic [IN_W:0] MAXV = (IN_W + 1)'((1 << (O_W - 1)) - 1);

    logic [IN_W:0] pos;
    logic [IN_W:0] rnd;

    // Clamp negatives to zero, add half an LSB of the result, shift, then clip to the int8 positive range.
    always_comb begin
        pos  = din[IN_W-1] ? '0 : {1'b0, din};
        rnd  = (pos + HALF) >> SHIFT;
        dout = (rnd > MAXV) ? MAXV[O_W-1:0] : rnd[O_W-1:0];
    end
endmodule

// File: rtl/dense_requant_relu.sv
// rtl/dense_requant_relu.sv - bias add, requant, relu and argmax after the dense MAC
module dense_requant_relu
    import dense_pkg::*;
#(
    parameter int SHIFT = SHIFT_DENSE
) (
    input  logic               clk,
    input  logic               rst,
    dense_requant_relu_if.slave bus
);
    localparam logic [IDX_W:0]   CNT_FULL = (IDX_W + 1)'(NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    logic [IDX_W:0]          count;
    logic                    accept;
    logic signed [ACC_W-1:0] acc0, acc1;
    logic [IDX_W-1:0]        idx0, idx1, idx2;
    logic                    v0, v1, v2;
    logic signed [SUM_W-1:0] sum1, sum2;
    logic [OUT_W-1:0]        q;

    assign accept = bus.busy & bus.acc_valid & (count < CNT_FULL);

    // The ROM answers the address issued in S0 during S1, so the bias lines up with acc1 here.
    assign sum1 = {acc1[ACC_W-1], acc1}
                + {{(SUM_W - BIAS_W){bus.bias_data[BIAS_W-1]}}, bus.bias_data};

    // S0: capture accumulator, issue bias ROM address, advance the neuron counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count         <= '0;
            acc0          <= '0;
            idx0          <= '0;
            v0            <= 1'b0;
            bus.bias_addr <= '0;
        end else if (bus.start) begin
            count <= '0;
            v0    <= 1'b0;
        end else begin
            v0 <= accept;
            if (accept) begin
                acc0          <= bus.acc_data;
                idx0          <= count[IDX_W-1:0];
                bus.bias_addr <= count[IDX_W-1:0];
                count         <= count + 1'b1;
            end
        end
    end

    // S1 waits out the ROM read; S2 holds the widened bias-added sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc1 <= '0;
            idx1 <= '0;
            v1   <= 1'b0;
            sum2 <= '0;
            idx2 <= '0;
            v2   <= 1'b0;
        end else if (bus.start) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            acc1 <= acc0;
            idx1 <= idx0;
            v1   <= v0;
            sum2 <= sum1;
            idx2 <= idx1;
            v2   <= v1;
        end
    end

    requant_sat #(
        .IN_W  (SUM_W),
        .O_W   (OUT_W),
        .SHIFT (SHIFT)
    ) u_requant_sat (
        .din  (sum2),
        .dout (q)
    );

    // Output write strobe towards the activation buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_addr  <= '0;
            bus.out_data  <= '0;
        end else if (bus.start) begin
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= v2;
            bus.out_addr  <= idx2;
            bus.out_data  <= q;
        end
    end

    // Block status and running argmax; strict compare keeps the lowest index on ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.argmax_idx <= '0;
            bus.argmax_val <= '0;
        end else if (bus.start) begin
            bus.busy       <= 1'b1;
            bus.done       <= 1'b0;
            bus.argmax_idx <= '0;
            bus.argmax_val <= '0;
        end else begin
            bus.done <= bus.out_valid && (bus.out_addr == LAST_IDX);
            if (bus.out_valid && (bus.out_addr == LAST_IDX)) begin
                bus.busy <= 1'b0;
            end
            if (bus.out_valid && (bus.out_data > bus.argmax_val)) begin
                bus.argmax_idx <= bus.out_addr;
                bus.argmax_val <= bus.out_data;
            end
        end
    end
endmodule

// File: tb/tb_dense_requant_relu.sv
// tb/tb_dense_requant_relu.sv - self-checking bench for dense_requant_relu
module tb_dense_requant_relu;
    import dense_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    dense_requant_relu_if bus();

    dense_requant_relu #(.SHIFT(SHIFT_DENSE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic signed [BIAS_W-1:0] rom [NUM_NEURONS];
    int obs_addr[$];
    int obs_data[$];
    int obs_cyc[$];
    int done_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read bias ROM
    always @(posedge clk) bus.bias_data <= rom[bus.bias_addr];

    // Output monitor
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            obs_addr.push_back(int'(bus.out_addr));
            obs_data.push_back(int'(bus.out_data));
            obs_cyc.push_back(cyc);
        end
        if (bus.done === 1'b1) done_cyc.push_back(cyc);
    end

    function automatic int ref_act(input longint acc, input longint bias);
        longint s;
        s = acc + bias;
        if (s < 0) s = 0;
        if (SHIFT_DENSE > 0) s = (s + (longint'(1) << (SHIFT_DENSE - 1))) / (longint'(1) << SHIFT_DENSE);
        if (s > OUT_MAX) s = OUT_MAX;
        return int'(s);
    endfunction

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic idle(input int n);
        bus.acc_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int d, output int k);
        bus.acc_valid = 1'b1;
        bus.acc_data  = d;
        @(posedge clk);
        #1;
        k = cyc;
        bus.acc_valid = 1'b0;
    endtask

    task automatic pulse_start(input bit with_acc);
        bus.start     = 1'b1;
        bus.acc_valid = with_acc;
        bus.acc_data  = 32'h7fff_0000;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.acc_valid = 1'b0;
    endtask

    function automatic logic [33:0] out_vec();
        return {bus.out_valid, bus.out_addr, bus.out_data, bus.argmax_idx,
                bus.argmax_val, bus.busy, bus.done, bus.bias_addr};
    endfunction

    task automatic test_reset();
        int k;
        checks++;
        if (out_vec() !== 34'd0) begin
            errors++;
            $display("FAIL reset_initial got %h expected 0", out_vec());
        end
        rst = 1'b0;
        for (int i = 0; i < NUM_NEURONS; i++) rom[i] = 16'sd5;
        pulse_start(1'b0);
        for (int i = 0; i < 4; i++) push(40000 + i * 1000, k);
        bus.acc_valid = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        clear_obs();
        checks++;
        if (out_vec() !== 34'd0) begin
            errors++;
            $display("FAIL reset_async got %h expected 0", out_vec());
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_vec() !== 34'd0) begin
            errors++;
            $display("FAIL reset_edge got %h expected 0", out_vec());
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) push(50000, k);
        idle(6);
        checks++;
        if (obs_data.size() != 0 || bus.busy !== 1'b0 || bus.bias_addr !== '0) begin
            errors++;
            $display("FAIL reset_idle_ignore got outs=%0d busy=%b addr=%0d expected 0 0 0",
                     obs_data.size(), bus.busy, bus.bias_addr);
        end
    endtask

    task automatic test_basic();
        int k0, k1;
        for (int i = 0; i < NUM_NEURONS; i++) rom[i] = '0;
        pulse_start(1'b0);
        clear_obs();
        push(32'h0000_3280, k0);
        push(32'h0000_327f, k1);
        idle(6);
        checks++;
        if (obs_data.size() != 2) begin
            errors++;
            $display("FAIL basic_count got %0d expected 2", obs_data.size());
        end else begin
            checks++;
            if (obs_data[0] != 'h33 || obs_addr[0] != 0 || obs_cyc[0] != k0 + 3) begin
                errors++;
                $display("FAIL basic_round_up got data=%0h addr=%0d cyc=%0d expected 33 0 %0d",
                         obs_data[0], obs_addr[0], obs_cyc[0], k0 + 3);
            end
            checks++;
            if (obs_data[1] != 'h32 || obs_addr[1] != 1 || obs_cyc[1] != k1 + 3) begin
                errors++;
                $display("FAIL basic_round_down got data=%0h addr=%0d cyc=%0d expected 32 1 %0d",
                         obs_data[1], obs_addr[1], obs_cyc[1], k1 + 3);
            end
        end
    endtask

    task automatic test_relu_sat();
        int k;
        int exp_d[3] = '{0, 127, 0};
        rom[0] = 16'sd100;
        rom[1] = 16'h7fff;
        rom[2] = 16'h8000;
        pulse_start(1'b0);
        clear_obs();
        push(-5000, k);
        push(32'h7fff_ffff, k);
        push(32'h8000_0000, k);
        idle(6);
        checks++;
        if (obs_data.size() != 3) begin
            errors++;
            $display("FAIL relu_sat_count got %0d expected 3", obs_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_data[i] != exp_d[i]) begin
                    errors++;
                    $display("FAIL relu_sat_%0d got %0d expected %0d", i, obs_data[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic check_full_layer(input string name, input int ks[NUM_NEURONS],
                                    input int exp_d[NUM_NEURONS]);
        int bi, bv;
        bi = 0;
        bv = 0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            if (exp_d[n] > bv) begin
                bv = exp_d[n];
                bi = n;
            end
        end
        checks++;
        if (obs_data.size() != NUM_NEURONS) begin
            errors++;
            $display("FAIL %s_count got %0d expected %0d", name, obs_data.size(), NUM_NEURONS);
        end
        for (int n = 0; n < NUM_NEURONS && n < obs_data.size(); n++) begin
            checks++;
            if (obs_addr[n] != n || obs_data[n] != exp_d[n] || obs_cyc[n] != ks[n] + 3) begin
                errors++;
                $display("FAIL %s_out%0d got addr=%0d data=%0d cyc=%0d expected %0d %0d %0d",
                         name, n, obs_addr[n], obs_data[n], obs_cyc[n], n, exp_d[n], ks[n] + 3);
            end
        end
        checks++;
        if (done_cyc.size() != 1) begin
            errors++;
            $display("FAIL %s_done_count got %0d expected 1", name, done_cyc.size());
        end else begin
            checks++;
            if (done_cyc[0] != ks[NUM_NEURONS-1] + 4) begin
                errors++;
                $display("FAIL %s_done_cyc got %0d expected %0d", name, done_cyc[0], ks[NUM_NEURONS-1] + 4);
            end
        end
        checks++;
        if (int'(bus.argmax_idx) != bi || int'(bus.argmax_val) != bv || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_argmax got idx=%0d val=%0d busy=%b expected %0d %0d 0",
                     name, bus.argmax_idx, bus.argmax_val, bus.busy, bi, bv);
        end
    endtask

    task automatic test_back_to_back();
        int ks[NUM_NEURONS];
        int exp_d[NUM_NEURONS];
        for (int i = 0; i < NUM_NEURONS; i++) rom[i] = '0;
        pulse_start(1'b0);
        clear_obs();
        for (int n = 0; n < NUM_NEURONS; n++) begin
            exp_d[n] = (n == 17 || n == 20) ? 120 : n;
            push(exp_d[n] * 256, ks[n]);
        end
        idle(6);
        check_full_layer("b2b", ks, exp_d);
    endtask

    task automatic test_overflow();
        int ks[NUM_NEURONS];
        int exp_d[NUM_NEURONS];
        int k;
        for (int i = 0; i < NUM_NEURONS; i++) rom[i] = '0;
        pulse_start(1'b0);
        clear_obs();
        for (int n = 0; n < NUM_NEURONS; n++) begin
            exp_d[n] = 100 - n;
            push(exp_d[n] * 256, ks[n]);
        end
        push(125 * 256, k);
        idle(6);
        checks++;
        if (bus.bias_addr !== IDX_W'(NUM_NEURONS - 1)) begin
            errors++;
            $display("FAIL overflow_bias_addr got %0d expected %0d", bus.bias_addr, NUM_NEURONS - 1);
        end
        check_full_layer("overflow", ks, exp_d);
    endtask

    task automatic test_start_mid_layer();
        int k;
        int accs[3];
        for (int i = 0; i < NUM_NEURONS; i++) rom[i] = 16'($urandom_range(0, 200));
        pulse_start(1'b0);
        clear_obs();
        for (int n = 0; n < 10; n++) push(int'($urandom_range(20000, 30000)), k);
        idle(1);
        pulse_start(1'b0);
        checks++;
        if (bus.argmax_idx !== '0 || bus.argmax_val !== '0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_start_clear got idx=%0d val=%0d busy=%b expected 0 0 1",
                     bus.argmax_idx, bus.argmax_val, bus.busy);
        end
        idle(5);
        checks++;
        if (obs_data.size() != 8 || done_cyc.size() != 0) begin
            errors++;
            $display("FAIL mid_start_flush got outs=%0d dones=%0d expected 8 0",
                     obs_data.size(), done_cyc.size());
        end
        clear_obs();
        for (int n = 0; n < 3; n++) begin
            accs[n] = int'($urandom_range(0, 40000)) - 10000;
            push(accs[n], k);
        end
        idle(6);
        checks++;
        if (obs_data.size() != 3) begin
            errors++;
            $display("FAIL mid_start_restart_count got %0d expected 3", obs_data.size());
        end else begin
            for (int n = 0; n < 3; n++) begin
                checks++;
                if (obs_addr[n] != n || obs_data[n] != ref_act(accs[n], rom[n])) begin
                    errors++;
                    $display("FAIL mid_start_restart%0d got addr=%0d data=%0d expected %0d %0d",
                             n, obs_addr[n], obs_data[n], n, ref_act(accs[n], rom[n]));
                end
            end
        end
    endtask

    task automatic test_random_layer(input int iter);
        int ks[NUM_NEURONS];
        int exp_d[NUM_NEURONS];
        int a;
        for (int i = 0; i < NUM_NEURONS; i++) rom[i] = 16'($urandom_range(0, 65535));
        pulse_start(1'b1);
        clear_obs();
        for (int n = 0; n < NUM_NEURONS; n++) begin
            a = int'($urandom_range(0, 80000)) - 30000;
            exp_d[n] = ref_act(a, rom[n]);
            push(a, ks[n]);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(6);
        check_full_layer($sformatf("rand%0d", iter), ks, exp_d);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.acc_valid = 1'b0;
        bus.acc_data  = '0;
        for (int i = 0; i < NUM_NEURONS; i++) rom[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_relu_sat();
        test_back_to_back();
        test_overflow();
        test_start_mid_layer();
        for (int i = 0; i < 3; i++) test_random_layer(i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
